// File: rtl/mecobo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mecobo_pkg
// Description : Shared constants for the sample-bus responders. Holds the
//               command-bus address split, register offsets, CTRL bit
//               indices, sample-word field positions, the responder state
//               encoding and a helper that builds a sample word.
// Revision    : 1.0 - initial release
// ============================================================================
package mecobo_pkg;

    // Bus widths
    localparam int c_CMD_ADDR_W = 16;
    localparam int c_CMD_DATA_W = 32;
    localparam int c_CHAN_W     = 8;
    localparam int c_SAMPLE_W   = 32;

    // Command address split: [15:8] block select, [7:0] register offset
    localparam int c_ADDR_BLK_HI = 15;
    localparam int c_ADDR_BLK_LO = 8;
    localparam int c_ADDR_REG_HI = 7;
    localparam int c_ADDR_REG_LO = 0;

    // Register offsets
    localparam logic [7:0] c_REG_CTRL       = 8'h00;
    localparam logic [7:0] c_REG_PERIOD     = 8'h01;
    localparam logic [7:0] c_REG_START_TIME = 8'h02;

    // CTRL bit indices
    localparam int c_CTRL_RUN_BIT   = 0;
    localparam int c_CTRL_FLUSH_BIT = 1;
    localparam int c_CTRL_EDGE_BIT  = 2;

    // Sample word fields
    localparam int c_SW_VALID = 31;
    localparam int c_SW_OVF   = 30;
    localparam int c_SW_TS_HI = 29;
    localparam int c_SW_TS_LO = 16;
    localparam int c_SW_VALUE = 0;

    // Responder state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ARMED    = 2'd1;
    localparam logic [1:0] c_ST_SAMPLING = 2'd2;

    // Builds a stored sample word; the overflow bit is always stored as 0
    // and is inserted only when the word is delivered on the bus.
    function automatic logic [c_SAMPLE_W-1:0] make_sample(input logic [13:0] ts,
                                                          input logic        val);
        logic [c_SAMPLE_W-1:0] w_word;
        w_word                        = '0;
        w_word[c_SW_VALID]            = 1'b1;
        w_word[c_SW_TS_HI:c_SW_TS_LO] = ts;
        w_word[c_SW_VALUE]            = val;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pin_sample_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : pin_sample_responder_if
// Description : Command bus (scheduler -> responder) and sample bus
//               (collector <-> responder) signals of one responder.
//               master : scheduler/collector side
//               slave  : responder side
//   enable, data_wr, addr[15:0], data_in[31:0] : command bus
//   output_sample, channel_select[7:0]         : poll request
//   sample_data[31:0]                          : wired-OR sample word
// Revision    : 1.0 - initial release
// ============================================================================
interface pin_sample_responder_if
    import mecobo_pkg::*;
;
    logic                    enable;
    logic                    data_wr;
    logic [c_CMD_ADDR_W-1:0] addr;
    logic [c_CMD_DATA_W-1:0] data_in;
    logic                    output_sample;
    logic [c_CHAN_W-1:0]     channel_select;
    logic [c_SAMPLE_W-1:0]   sample_data;

    modport master (
        output enable,
        output data_wr,
        output addr,
        output data_in,
        output output_sample,
        output channel_select,
        input  sample_data
    );

    modport slave (
        input  enable,
        input  data_wr,
        input  addr,
        input  data_in,
        input  output_sample,
        input  channel_select,
        output sample_data
    );

endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous fall-through FIFO. o_head always shows the
//               oldest entry. A push into a full FIFO is accepted only when a
//               pop happens in the same cycle. Flush wins over push/pop.
//   clk, reset (async, active-high)
//   i_flush, i_push, i_push_data[WIDTH-1:0], i_pop
//   o_head[WIDTH-1:0], o_full, o_empty
//   DEPTH must be a power of two (4..256).
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // Full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/pin_sample_responder.sv
`default_nettype none
// ============================================================================
// Module      : pin_sample_responder
// Description : Samples one header pin against the global time base on a
//               programmable period, buffers tagged samples in a FIFO and
//               returns the FIFO head on the wired-OR sample bus when polled
//               on its own channel.
//   clk, reset (async, active-high)
//   bus          : command bus + sample bus (slave modport)
//   pin          : asynchronous header pin
//   current_time : global time base (synchronous to clk)
//   overflow     : sticky FIFO overflow status
//   Optional macro SAMPLE_EDGE_EN: enables CTRL.EDGE_MODE (capture on
//   synced-pin change instead of the period counter).
// Revision    : 1.0 - initial release
// ============================================================================
module pin_sample_responder
    import mecobo_pkg::*;
#(
    parameter logic [7:0] POSITION = 8'd0,
    parameter int         DEPTH    = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    pin_sample_responder_if.slave      bus,
    input  wire logic                  pin,
    input  wire logic [31:0]           current_time,
    output logic                       overflow
);

    // ------------------------------------------------------------------
    // Command register writes
    // ------------------------------------------------------------------
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic [7:0]  w_reg_off;
    logic        r_run;
    logic [31:0] r_period;
    logic [31:0] r_start_time;
    logic [31:0] w_period_eff;

    assign w_reg_off = bus.addr[c_ADDR_REG_HI:c_ADDR_REG_LO];
    assign w_wr      = bus.enable & bus.data_wr
                     & (bus.addr[c_ADDR_BLK_HI:c_ADDR_BLK_LO] == POSITION);
    assign w_ctrl_wr = w_wr & (w_reg_off == c_REG_CTRL);
    // FLUSH is never stored: it acts on the same edge that takes the write
    assign w_flush   = w_ctrl_wr & bus.data_in[c_CTRL_FLUSH_BIT];
    assign w_period_eff = (r_period == 32'd0) ? 32'd1 : r_period;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_period     <= 32'd0;
            r_start_time <= 32'd0;
        end else if (w_wr) begin
            if (w_reg_off == c_REG_CTRL)       r_run        <= bus.data_in[c_CTRL_RUN_BIT];
            if (w_reg_off == c_REG_PERIOD)     r_period     <= bus.data_in;
            if (w_reg_off == c_REG_START_TIME) r_start_time <= bus.data_in;
        end
    end

`ifdef SAMPLE_EDGE_EN
    logic r_edge_mode;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_edge_mode <= 1'b0;
        else if (w_ctrl_wr) r_edge_mode <= bus.data_in[c_CTRL_EDGE_BIT];
    end
`endif

    // ------------------------------------------------------------------
    // Pin synchroniser and time-base tick
    // ------------------------------------------------------------------
    logic        r_pin_meta;
    logic        r_pin_sync;
    logic [31:0] r_prev_time;
    logic        w_tick;
    logic        w_time_reached;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pin_meta  <= 1'b0;
            r_pin_sync  <= 1'b0;
            r_prev_time <= 32'd0;
        end else begin
            r_pin_meta  <= pin;
            r_pin_sync  <= r_pin_meta;
            r_prev_time <= current_time;
        end
    end

    // Any change counts, so the 0xFFFFFFFF -> 0 wrap is a tick too
    assign w_tick         = (current_time != r_prev_time);
    assign w_time_reached = (current_time >= r_start_time);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       w_capture;
    logic [31:0] r_cnt;
    logic        r_first;   // SAMPLING entered without a tick: capture on the next one
`ifdef SAMPLE_EDGE_EN
    logic        r_last_val;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!r_run) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:     w_state_next = c_ST_ARMED;
                c_ST_ARMED:    if (w_time_reached) w_state_next = c_ST_SAMPLING;
                c_ST_SAMPLING: w_state_next = c_ST_SAMPLING;
                default:       w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_capture = 1'b0;
        if (r_run && w_tick) begin
            case (r_state)
                // The tick that moves ARMED -> SAMPLING is the first capture
                c_ST_ARMED: w_capture = w_time_reached;
                c_ST_SAMPLING: begin
                    if (r_first) w_capture = 1'b1;
`ifdef SAMPLE_EDGE_EN
                    else if (r_edge_mode) w_capture = (r_pin_sync != r_last_val);
`endif
                    else if (r_cnt <= 32'd1) w_capture = 1'b1;
                end
                default: w_capture = 1'b0;
            endcase
        end
    end

    // Period counter: reloads on every capture, decrements on other ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 32'd0;
            r_first <= 1'b0;
        end else if (r_state == c_ST_ARMED && w_state_next == c_ST_SAMPLING) begin
            r_cnt   <= w_period_eff;
            r_first <= ~w_tick;
        end else if (r_state == c_ST_SAMPLING && w_tick) begin
            r_first <= 1'b0;
            if (w_capture)           r_cnt <= w_period_eff;
            else if (r_cnt > 32'd1)  r_cnt <= r_cnt - 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: entry is pushed on the cycle after the tick
    // ------------------------------------------------------------------
    logic        r_cap_valid;
    logic [31:0] r_cap_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_valid <= 1'b0;
            r_cap_data  <= 32'd0;
        end else begin
            r_cap_valid <= w_capture;
            if (w_capture) r_cap_data <= make_sample(current_time[13:0], r_pin_sync);
        end
    end

`ifdef SAMPLE_EDGE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_last_val <= 1'b0;
        else if (w_capture) r_last_val <= r_pin_sync;
    end
`endif

    // ------------------------------------------------------------------
    // FIFO, overflow tracking and sample bus
    // ------------------------------------------------------------------
    logic [31:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_poll;
    logic        w_pop;
    logic        w_drop;
    logic        r_overflow;
    logic        r_ovf_pending;   // marks the next delivered word

    assign w_poll = bus.output_sample & (bus.channel_select == POSITION);
    assign w_pop  = w_poll & ~w_empty;
    assign w_drop = r_cap_valid & w_full & ~w_pop & ~w_flush;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_flush),
        .i_push      (r_cap_valid),
        .i_push_data (r_cap_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_ovf_pending <= 1'b0;
        end else if (w_flush) begin
            r_overflow    <= 1'b0;
            r_ovf_pending <= 1'b0;
        end else if (w_drop) begin
            r_overflow    <= 1'b1;
            r_ovf_pending <= 1'b1;
        end else if (w_pop) begin
            r_ovf_pending <= 1'b0;
        end
    end

    assign overflow        = r_overflow;
    assign bus.sample_data = w_pop ? {w_head[c_SW_VALID], r_ovf_pending, w_head[c_SW_TS_HI:0]}
                                   : 32'd0;

endmodule
`default_nettype wire
